atmega_tim_input_capture: RTL

- ATmega-style 16-bit input-capture timer. It is the receive-side counterpart of the 8-bit waveform timer: the timer drives OC pins, and this block measures edges arriving on an ICP pin.
- A prescaled free-running 16-bit counter is snapshotted into ICR on a selected edge of the synchronized, optionally noise-cancelled ICP input.
- It sits on the 8-bit IO bus next to the other timers, shares the prescaler taps, and raises capture and overflow interrupt flags.

---
 rtl/atmega_tim_input_capture_if.sv | 27 ++
 rtl/atmega_tim_input_capture.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/atmega_tim_input_capture_if.sv
// 8-bit IO bus bundle shared by the timer peripherals: address, strobes and data.
// The master drives address/strobes/write data; the slave returns combinational read data.
interface atmega_tim_input_capture_if #(
    parameter int BUS_ADDR_DATA_LEN = 8
);
    logic [BUS_ADDR_DATA_LEN-1:0] addr;
    logic                         wr;
    logic                         rd;
    logic [7:0]                   bus_in;
    logic [7:0]                   bus_out;

    modport master (
        output addr,
        output wr,
        output rd,
        output bus_in,
        input  bus_out
    );

    modport slave (
        input  addr,
        input  wr,
        input  rd,
        input  bus_in,
        output bus_out
    );
endinterface

// File: rtl/atmega_tim_input_capture.sv
// 16-bit input-capture timer: a prescaled free-running counter is snapshotted into ICR
// on a selected edge of the synchronized, optionally noise-filtered ICP pin.
module atmega_tim_input_capture #(
    parameter int                           BUS_ADDR_DATA_LEN = 8,
    parameter logic [BUS_ADDR_DATA_LEN-1:0] ICCR_ADDR  = 'h80,
    parameter logic [BUS_ADDR_DATA_LEN-1:0] ICNTL_ADDR = 'h84,
    parameter logic [BUS_ADDR_DATA_LEN-1:0] ICNTH_ADDR = 'h85,
    parameter logic [BUS_ADDR_DATA_LEN-1:0] ICRL_ADDR  = 'h86,
    parameter logic [BUS_ADDR_DATA_LEN-1:0] ICRH_ADDR  = 'h87,
    parameter logic [BUS_ADDR_DATA_LEN-1:0] ICMSK_ADDR = 'h6F,
    parameter logic [BUS_ADDR_DATA_LEN-1:0] ICFR_ADDR  = 'h36
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clk8_i,
    input  logic clk64_i,
    input  logic clk256_i,
    input  logic clk1024_i,
    atmega_tim_input_capture_if.slave bus,
    input  logic icp_i,
    output logic icf_int_o,
    input  logic icf_int_rst_i,
    output logic ovf_int_o,
    input  logic ovf_int_rst_i
);

    // Control / status registers
    logic [2:0]  cs_q, cs_d;
    logic        icauto_q, icauto_d;
    logic        ices_q, ices_d;
    logic        icnc_q, icnc_d;
    logic        icie_q, icie_d;
    logic        ovie_q, ovie_d;
    logic        icf_q, icf_d;
    logic        ovf_q, ovf_d;
    logic        icovr_q, icovr_d;
    logic [15:0] icnt_q, icnt_d;
    logic [15:0] icr_q, icr_d;
    logic [7:0]  temp_q, temp_d;

    // Input conditioning
    logic [1:0]  sync_q;
    logic [2:0]  hist_q;
    logic        filt_q, filt_d;
    logic        icp_s;

    // Prescaler tap edge detection
    logic [3:0]  taps;
    logic [3:0]  tap_q;
    logic [3:0]  tap_rise;

    logic        tick;
    logic        run;
    logic        capture;
    logic        wrap;

    logic        wr_iccr, wr_icntl, wr_icnth, wr_icmsk, wr_icfr;
    logic        rd_icntl, rd_icrl;
    logic        clr_icf, clr_icovr, clr_ovf;
    logic [7:0]  rdata;

    assign taps = {clk1024_i, clk256_i, clk64_i, clk8_i};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_tap
            assign tap_rise[gi] = taps[gi] & ~tap_q[gi];
        end
    endgenerate

    always_comb begin
        tick = 1'b0;
        case (cs_q)
            3'b001:  tick = 1'b1;
            3'b010:  tick = tap_rise[0];
            3'b011:  tick = tap_rise[1];
            3'b100:  tick = tap_rise[2];
            3'b101:  tick = tap_rise[3];
            default: tick = 1'b0;
        endcase
    end

    assign run = (cs_q != 3'b000) && (cs_q < 3'b110);

    // Bus decode
    assign wr_iccr  = bus.wr && (bus.addr == ICCR_ADDR);
    assign wr_icntl = bus.wr && (bus.addr == ICNTL_ADDR);
    assign wr_icnth = bus.wr && (bus.addr == ICNTH_ADDR);
    assign wr_icmsk = bus.wr && (bus.addr == ICMSK_ADDR);
    assign wr_icfr  = bus.wr && (bus.addr == ICFR_ADDR);
    assign rd_icntl = bus.rd && (bus.addr == ICNTL_ADDR);
    assign rd_icrl  = bus.rd && (bus.addr == ICRL_ADDR);

    assign icp_s = sync_q[1];

    // With the canceller on, the filter only follows a level seen on 4 consecutive samples.
    always_comb begin
        filt_d = icp_s;
        if (icnc_q && (hist_q != {3{icp_s}})) begin
            filt_d = filt_q;
        end
    end

    assign capture = run && (filt_d != filt_q) && (filt_d == ices_q);

    assign clr_icf   = (wr_icfr && bus.bus_in[0]) || icf_int_rst_i;
    assign clr_ovf   = (wr_icfr && bus.bus_in[1]) || ovf_int_rst_i;
    assign clr_icovr = (wr_icfr && bus.bus_in[2]) || icf_int_rst_i;

    // Wrap only counts when the increment actually happens (not overridden by a load/clear).
    assign wrap = tick && (icnt_q == 16'hFFFF) && !wr_icntl && !(capture && icauto_q);

    always_comb begin
        cs_d     = cs_q;
        icauto_d = icauto_q;
        ices_d   = ices_q;
        icnc_d   = icnc_q;
        if (wr_iccr) begin
            cs_d     = bus.bus_in[2:0];
            icauto_d = bus.bus_in[3];
            ices_d   = bus.bus_in[6];
            icnc_d   = bus.bus_in[7];
        end

        icie_d = icie_q;
        ovie_d = ovie_q;
        if (wr_icmsk) begin
            icie_d = bus.bus_in[0];
            ovie_d = bus.bus_in[1];
        end

        if (wr_icntl) begin
            icnt_d = {temp_q, bus.bus_in};
        end else if (capture && icauto_q) begin
            icnt_d = 16'h0000;
        end else if (tick) begin
            icnt_d = icnt_q + 16'h0001;
        end else begin
            icnt_d = icnt_q;
        end

        icr_d = capture ? icnt_q : icr_q;

        if (wr_icnth) begin
            temp_d = bus.bus_in;
        end else if (rd_icntl) begin
            temp_d = icnt_q[15:8];
        end else if (rd_icrl) begin
            temp_d = icr_q[15:8];
        end else begin
            temp_d = temp_q;
        end

        // A set arriving in the same cycle as a clear takes precedence.
        if (capture)      icf_d = 1'b1;
        else if (clr_icf) icf_d = 1'b0;
        else              icf_d = icf_q;

        if (capture && icf_q) icovr_d = 1'b1;
        else if (clr_icovr)   icovr_d = 1'b0;
        else                  icovr_d = icovr_q;

        if (wrap)         ovf_d = 1'b1;
        else if (clr_ovf) ovf_d = 1'b0;
        else              ovf_d = ovf_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_q     <= 3'b000;
            icauto_q <= 1'b0;
            ices_q   <= 1'b0;
            icnc_q   <= 1'b0;
            icie_q   <= 1'b0;
            ovie_q   <= 1'b0;
            icf_q    <= 1'b0;
            ovf_q    <= 1'b0;
            icovr_q  <= 1'b0;
            icnt_q   <= 16'h0000;
            icr_q    <= 16'h0000;
            temp_q   <= 8'h00;
            sync_q   <= 2'b00;
            hist_q   <= 3'b000;
            filt_q   <= 1'b0;
            tap_q    <= 4'b0000;
        end else begin
            cs_q     <= cs_d;
            icauto_q <= icauto_d;
            ices_q   <= ices_d;
            icnc_q   <= icnc_d;
            icie_q   <= icie_d;
            ovie_q   <= ovie_d;
            icf_q    <= icf_d;
            ovf_q    <= ovf_d;
            icovr_q  <= icovr_d;
            icnt_q   <= icnt_d;
            icr_q    <= icr_d;
            temp_q   <= temp_d;
            sync_q   <= {sync_q[0], icp_i};
            hist_q   <= {hist_q[1:0], icp_s};
            filt_q   <= filt_d;
            tap_q    <= taps;
        end
    end

    always_comb begin
        rdata = 8'h00;
        if (bus.rd) begin
            case (bus.addr)
                ICCR_ADDR:  rdata = {icnc_q, ices_q, 2'b00, icauto_q, cs_q};
                ICNTL_ADDR: rdata = icnt_q[7:0];
                ICNTH_ADDR: rdata = temp_q;
                ICRL_ADDR:  rdata = icr_q[7:0];
                ICRH_ADDR:  rdata = temp_q;
                ICMSK_ADDR: rdata = {6'b000000, ovie_q, icie_q};
                ICFR_ADDR:  rdata = {5'b00000, icovr_q, ovf_q, icf_q};
                default:    rdata = 8'h00;
            endcase
        end
    end

    assign bus.bus_out = rdata;
    assign icf_int_o   = icf_q & icie_q;
    assign ovf_int_o   = ovf_q & ovie_q;

endmodule
